// File: rtl/rr_arbiter8_index_pkg.sv
// Shared constants and state encoding for the 8-way round-robin index arbiter.
package rr_arb_pkg;

  localparam int N_REQ    = 8;
  localparam int IDX_W    = 3;
  localparam int MAX_HOLD = 15;
  localparam int HOLD_W   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_t;

  // Channel after i; the 3-bit add wraps 7 -> 0 on its own.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return i + IDX_W'(1);
  endfunction

endpackage

// File: rtl/rr_arbiter8_index_if.sv
// Request/grant bundle between the requesters and the round-robin arbiter.
interface rr_arbiter8_index_if;
  import rr_arb_pkg::*;

  logic [N_REQ-1:0]  req;
  logic              release_i;
  logic [IDX_W-1:0]  grant_idx;
  logic              grant_valid;
  logic              timeout;
  logic [HOLD_W-1:0] hold_cnt;

  modport master (
    output req, release_i,
    input  grant_idx, grant_valid, timeout, hold_cnt
  );

  modport slave (
    input  req, release_i,
    output grant_idx, grant_valid, timeout, hold_cnt
  );
endinterface

// File: rtl/rr_pick8.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping 7 -> 0.
module rr_pick8
  import rr_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [2*N_REQ-2:0] dbl;
  logic [IDX_W:0]     base;
  logic [N_REQ-1:0]   rot;
  logic [IDX_W-1:0]   off;

  // NOTE: every output of this block is given a default before the search,
  // so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    dbl  = {req[N_REQ-2:0], req};
    base = {1'b0, ptr};
    rot  = dbl[base +: N_REQ];
    any  = |req;
    off  = '0;
    // Walk downward so the lowest set bit of the rotated vector wins.
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (rot[j]) off = IDX_W'(j);
    end
    idx = ptr + off;
  end

endmodule

// File: rtl/rr_arbiter8_index.sv
// Round-robin arbiter for 8 requesters with registered grant index, bounded hold and a one-cycle gap between owners.
module rr_arbiter8_index
  import rr_arb_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  rr_arbiter8_index_if.slave   bus
);

  arb_state_t        state;
  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  grant_idx_q;
  logic              grant_valid_q;
  logic              timeout_q;
  logic [HOLD_W-1:0] hold_q;

  logic [IDX_W-1:0]  pick_idx;
  logic              pick_any;
  logic              granted_req;
  logic              hit_max;
  logic              exit_grant;

  rr_pick8 u_pick (
    .req (bus.req),
    .ptr (ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign granted_req = bus.req[grant_idx_q];
  assign hit_max     = (hold_q == HOLD_W'(MAX_HOLD));
  assign exit_grant  = bus.release_i | ~granted_req | hit_max;

  // NOTE: state registers use non-blocking assignments only, and the
  // asynchronous reset clears every one of them so grant_valid drops without a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      ptr           <= '0;
      grant_idx_q   <= '0;
      grant_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
      hold_q        <= '0;
    end else begin
      timeout_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pick_any) begin
            grant_idx_q   <= pick_idx;
            grant_valid_q <= 1'b1;
            hold_q        <= '0;
            state         <= GRANT;
          end
        end
        GRANT: begin
          if (exit_grant) begin
            state         <= GAP;
            grant_valid_q <= 1'b0;
            ptr           <= next_idx(grant_idx_q);
            // A release in the same cycle as the hold limit is a normal release.
            timeout_q     <= hit_max & ~bus.release_i & granted_req;
          end else if (!hit_max) begin
            hold_q <= hold_q + HOLD_W'(1);
          end
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.grant_idx   = grant_idx_q;
  assign bus.grant_valid = grant_valid_q;
  assign bus.timeout     = timeout_q;
  assign bus.hold_cnt    = hold_q;

endmodule

// File: tb/tb_rr_arbiter8_index.sv
// Scoreboard bench for rr_arbiter8_index: a per-cycle reference model queues expected outputs, a negedge monitor compares.
module tb_rr_arbiter8_index;
  import rr_arb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rr_arbiter8_index_if bus ();

  rr_arbiter8_index dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit valid;
    int idx;
    bit to;
    int hold;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model: who owns the bus, for how long, and where the search starts next.
  bit m_valid;
  int m_idx;
  bit m_to;
  int m_hold;
  int m_ptr;
  bit m_gap;

  // Event logs for the directed scenarios.
  int grants[$];
  int lens[$];
  int n_to;
  int run;
  bit run_logged;
  bit prev_valid = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_idx   = 0;
    m_to    = 1'b0;
    m_hold  = 0;
    m_ptr   = 0;
    m_gap   = 1'b0;
  endtask

  task automatic model_step();
    bit still_req;
    if (rst) begin
      model_reset();
    end else begin
      m_to = 1'b0;
      if (m_valid) begin
        still_req = bus.req[m_idx];
        if (bus.release_i || !still_req || m_hold == MAX_HOLD) begin
          m_to    = (m_hold == MAX_HOLD) && !bus.release_i && still_req;
          m_valid = 1'b0;
          m_gap   = 1'b1;
          m_ptr   = (m_idx + 1) % N_REQ;
        end else if (m_hold < MAX_HOLD) begin
          m_hold++;
        end
      end else if (m_gap) begin
        m_gap = 1'b0;
      end else if (bus.req != '0) begin
        for (int k = 0; k < N_REQ; k++) begin
          int c;
          c = (m_ptr + k) % N_REQ;
          if (bus.req[c]) begin
            m_idx = c;
            break;
          end
        end
        m_valid = 1'b1;
        m_hold  = 0;
      end
    end
    sb.push_back('{m_valid, m_idx, m_to, m_hold});
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic clear_logs();
    grants.delete();
    lens.delete();
    n_to       = 0;
    run_logged = 1'b0;
  endtask

  task automatic run_until(input int n, input int rel_at, input int budget);
    int i = 0;
    while (grants.size() < n && i < budget) begin
      bus.release_i = m_valid && (m_hold == rel_at);
      cycle();
      i++;
    end
    bus.release_i = 1'b0;
    if (grants.size() < n) check("grant_wait_budget", grants.size(), n);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("grant_valid", bus.grant_valid, e.valid);
      check("grant_idx",   bus.grant_idx,   e.idx);
      check("timeout",     bus.timeout,     e.to);
      check("hold_cnt",    bus.hold_cnt,    e.hold);
    end
    if (bus.grant_valid && !prev_valid) begin
      grants.push_back(bus.grant_idx);
      run        = 0;
      run_logged = 1'b1;
    end
    if (bus.grant_valid) run++;
    if (!bus.grant_valid && prev_valid && run_logged) lens.push_back(run);
    if (bus.timeout) n_to++;
    prev_valid = bus.grant_valid;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus.req       = 8'hFF;
    bus.release_i = 1'b0;
    model_reset();
    clear_logs();

    // Reset with every channel requesting.
    #1;
    check("reset_valid",   bus.grant_valid, 0);
    check("reset_idx",     bus.grant_idx,   0);
    check("reset_timeout", bus.timeout,     0);
    check("reset_hold",    bus.hold_cnt,    0);
    repeat (3) cycle();
    rst = 1'b0;
    cycle();
    check("first_grant_valid", bus.grant_valid, 1);
    check("first_grant_idx",   bus.grant_idx,   0);

    // Full round robin, release on the third GRANT cycle.
    clear_logs();
    run_until(9, 2, 200);
    check("rr_count", grants.size(), 9);
    for (int i = 0; i < grants.size(); i++) check($sformatf("rr_seq[%0d]", i), grants[i], i % 8);
    for (int i = 0; i < lens.size(); i++) check($sformatf("rr_len[%0d]", i), lens[i], 3);

    // Park ptr at 6, then sparse requests that wrap.
    clear_logs();
    bus.req = 8'h20;
    run_until(1, 1, 50);
    bus.req = 8'b0000_0101;
    run_until(3, 1, 50);
    bus.req = 8'b1000_0000;
    run_until(4, 1, 50);
    bus.req = 8'hFF;
    run_until(5, 1, 50);
    check("wrap_count", grants.size(), 5);
    if (grants.size() == 5) begin
      check("wrap_park", grants[0], 5);
      check("wrap_0",    grants[1], 0);
      check("wrap_2",    grants[2], 2);
      check("wrap_7",    grants[3], 7);
      check("wrap_ptr0", grants[4], 0);
    end

    // Hold timeout with a request that never lets go.
    clear_logs();
    bus.req = 8'h10;
    run_until(2, -1, 100);
    check("to_count", grants.size(), 2);
    if (grants.size() == 2) begin
      check("to_idx_a", grants[0], 4);
      check("to_idx_b", grants[1], 4);
    end
    check("to_len_count", lens.size(), 1);
    if (lens.size() >= 1) check("to_len", lens[0], 16);
    check("to_pulses", n_to, 1);

    // Request withdrawn mid-grant.
    clear_logs();
    bus.req = 8'h08;
    run_until(1, -1, 60);
    repeat (3) cycle();
    bus.req = 8'h01;
    cycle();
    check("drop_valid",   bus.grant_valid, 0);
    check("drop_timeout", bus.timeout,     0);

    // Release coinciding with the hold limit.
    clear_logs();
    bus.req = 8'h08;
    for (int i = 0; i < 60 && lens.size() < 1; i++) begin
      bus.release_i = m_valid && (m_hold == MAX_HOLD);
      cycle();
    end
    bus.release_i = 1'b0;
    cycle();
    check("relmax_len_count", lens.size(), 1);
    if (lens.size() >= 1) check("relmax_len", lens[0], 16);
    check("relmax_pulses", n_to, 0);

    // Asynchronous reset in the middle of a grant.
    clear_logs();
    bus.req = 8'hFF;
    run_until(1, -1, 40);
    repeat (2) cycle();
    check("pre_reset_valid", bus.grant_valid, 1);
    #2;
    rst = 1'b1;
    sb.delete();
    model_reset();
    #1;
    check("async_valid",   bus.grant_valid, 0);
    check("async_idx",     bus.grant_idx,   0);
    check("async_timeout", bus.timeout,     0);
    check("async_hold",    bus.hold_cnt,    0);
    repeat (2) cycle();
    rst = 1'b0;
    clear_logs();
    run_until(1, -1, 20);
    check("restart_count", grants.size(), 1);
    if (grants.size() == 1) check("restart_idx", grants[0], 0);

    // Random traffic against the model.
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 3) == 0) bus.req = 8'($urandom_range(0, 255) & $urandom_range(0, 255));
      bus.release_i = ($urandom_range(0, 5) == 0);
      cycle();
    end
    bus.release_i = 1'b0;
    cycle();
    #6;
    check("scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
